// File: rtl/ifetch_stage.sv
// ifetch_stage: RV64 instruction fetch with PC ownership, redirect/stale-drop handling and output buffer.
// Define IFETCH_SKID_EN for a 2-entry skid buffer; otherwise a single entry.
module ifetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic [64:0] branch,
    input  logic [64:0] csr_flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [95:0] out_data,
    output logic        out_misaligned
);
`ifdef IFETCH_SKID_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif
    typedef enum logic [1:0] {REQ, DROP, WAIT, HALT} state_t;
    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d, stale_q, target;
    logic [1:0]  cnt_q, cnt_d, cnt_pop;
    logic [96:0] head_q, head_d, tail_q, tail_d, push_ent;
    logic        redir, pop, push;
    // branch/csr_flush are {valid, target}; buffer entries are {misaligned, raw_instr, pc}
    assign redir          = branch[64] | csr_flush[64];
    assign target         = csr_flush[64] ? csr_flush[63:0] : branch[63:0];
    assign out_valid      = cnt_q != 2'd0;
    assign pop            = out_valid & out_ready;
    assign cnt_pop        = cnt_q - {1'b0, pop};
    assign out_data       = out_valid ? head_q[95:0] : 96'd0;
    assign out_misaligned = out_valid & head_q[96];
    assign ireq_valid     = !reset && ((state_q == REQ && pc_q[1:0] == 2'b00) || state_q == DROP);
    assign ireq_addr      = state_q == DROP ? stale_q : pc_q;
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        push     = 1'b0;
        push_ent = {1'b0, iresp_data, pc_q};
        case (state_q)
            REQ: begin
                if (pc_q[1:0] != 2'b00) begin
                    if (cnt_pop < DEPTH) begin
                        push     = 1'b1;
                        push_ent = {1'b1, 32'h0000_0013, pc_q};
                        state_d  = HALT;
                    end
                end else if (iresp_data_ok) begin
                    push    = 1'b1;
                    pc_d    = pc_q + 64'd4;
                    state_d = cnt_pop < DEPTH - 2'd1 ? REQ : WAIT;
                end
            end
            DROP:    state_d = iresp_data_ok ? REQ : DROP;
            WAIT:    state_d = cnt_pop < DEPTH ? REQ : WAIT;
            default: state_d = HALT;
        endcase
        // a redirect never withdraws a live request; its response is dropped in DROP
        if (redir) begin
            push    = 1'b0;
            pc_d    = target;
            state_d = (ireq_valid && !iresp_data_ok) ? DROP : REQ;
        end
        cnt_d  = redir ? 2'd0 : cnt_pop + {1'b0, push};
        head_d = (pop && cnt_q == 2'd2) ? tail_q : (push && cnt_pop == 2'd0) ? push_ent : head_q;
        tail_d = (push && cnt_pop == 2'd1) ? push_ent : tail_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            stale_q <= RESET_PC;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= state_q == DROP ? stale_q : pc_q;
            cnt_q   <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end
endmodule
